wildcard_seq_scanner: RTL



---
 rtl/wildcard_seq_scanner.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/wildcard_seq_scanner.sv
// Streaming wildcard sequence detector: loads a DEPTH-word pattern/mask, then flags every
// window of the last DEPTH accepted words that matches. Optional: WILDCARD_SCANNER_COUNT_WRAP_EN.

module wildcard_seq_scanner_cmp #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] hist_i,
  input  logic [WIDTH-1:0] pat_i,
  input  logic [WIDTH-1:0] mask_i,
  output logic             hit_o
);
  assign hit_o = ((hist_i ^ pat_i) & ~mask_i) == '0;
endmodule

module wildcard_seq_scanner #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic [WIDTH-1:0] cfg_mask,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             scanning
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SCAN} state_e;

  state_e                        state_q, state_d;
  logic [IW-1:0]                 load_idx_q, load_idx_d;
  logic [DEPTH-1:0][WIDTH-1:0]   pat_q, pat_d;
  logic [DEPTH-1:0][WIDTH-1:0]   mask_q, mask_d;
  logic [DEPTH-1:0][WIDTH-1:0]   hist_q, hist_d;
  logic [FW-1:0]                 fill_q, fill_d;
  logic                          match_q, match_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;

  logic [DEPTH-1:0][WIDTH-1:0]   hist_shift;
  logic [DEPTH-1:0]              hit;
  logic [FW-1:0]                 fill_inc;
  logic [CNT_W-1:0]              cnt_inc;

  // Window compare runs on the shifted history so the word being accepted is included.
  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++) hist_shift[i] = hist_q[i+1];
    hist_shift[DEPTH-1] = in_data;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
    wildcard_seq_scanner_cmp #(.WIDTH(WIDTH)) u_cmp (
      .hist_i (hist_shift[g]),
      .pat_i  (pat_q[g]),
      .mask_i (mask_q[g]),
      .hit_o  (hit[g])
    );
  end

  assign fill_inc = (fill_q == FW'(DEPTH)) ? fill_q : fill_q + 1'b1;

`ifdef WILDCARD_SCANNER_COUNT_WRAP_EN
  assign cnt_inc = cnt_q + 1'b1;
`else
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    load_idx_d = load_idx_q;
    pat_d      = pat_q;
    mask_d     = mask_q;
    hist_d     = hist_q;
    fill_d     = fill_q;
    cnt_d      = cnt_q;
    match_d    = 1'b0;
    if (clear) begin
      state_d    = IDLE;
      load_idx_d = '0;
      pat_d      = '0;
      mask_d     = '0;
      hist_d     = '0;
      fill_d     = '0;
      cnt_d      = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d    = LOAD;
          load_idx_d = '0;
        end
        LOAD: begin
          if (cfg_valid) begin
            pat_d[load_idx_q]  = cfg_data;
            mask_d[load_idx_q] = cfg_mask;
            if (load_idx_q == IW'(DEPTH - 1)) begin
              state_d    = SCAN;
              load_idx_d = '0;
              hist_d     = '0;
              fill_d     = '0;
              cnt_d      = '0;
            end else begin
              load_idx_d = load_idx_q + 1'b1;
            end
          end
        end
        SCAN: begin
          if (in_valid) begin
            hist_d = hist_shift;
            fill_d = fill_inc;
            if (fill_inc == FW'(DEPTH) && (&hit)) begin
              match_d = 1'b1;
              cnt_d   = cnt_inc;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      load_idx_q <= '0;
      pat_q      <= '0;
      mask_q     <= '0;
      hist_q     <= '0;
      fill_q     <= '0;
      match_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      load_idx_q <= load_idx_d;
      pat_q      <= pat_d;
      mask_q     <= mask_d;
      hist_q     <= hist_d;
      fill_q     <= fill_d;
      match_q    <= match_d;
      cnt_q      <= cnt_d;
    end
  end

  assign cfg_ready   = (state_q == LOAD);
  assign in_ready    = (state_q == SCAN);
  assign scanning    = (state_q == SCAN);
  assign match       = match_q;
  assign match_count = cnt_q;
endmodule
